// File: rtl/usb_comma_align_ctrl_if.sv
// Deserializer-to-aligner bundle: 10-bit bit-clock window in, aligned symbols and lock status out.
interface usb_comma_align_ctrl_if;
  logic [9:0] par_in;
  logic       align_en;
  logic [9:0] sym_out;
  logic       sym_valid;
  logic       sym_is_comma;
  logic       locked;
  logic       lock_lost;

  // master = deserializer / symbol consumer side, slave = the aligner
  modport master (
    output par_in, align_en,
    input  sym_out, sym_valid, sym_is_comma, locked, lock_lost
  );

  modport slave (
    input  par_in, align_en,
    output sym_out, sym_valid, sym_is_comma, locked, lock_lost
  );
endinterface

// File: rtl/usb_comma_align_ctrl.sv
// K28.5 comma aligner: hunts, verifies and tracks the 10-bit boundary; symbols 1 cycle after the boundary.
// Macro USB_ALIGN_RDPOS_EN also accepts the RD+ comma (10'h283); no backpressure, one symbol per 10 bit clocks.
module usb_comma_align_ctrl #(
  parameter int VERIFY_COMMAS = 3,
  parameter int ERR_LIMIT     = 4
) (
  input logic                    clk,
  input logic                    rst,
  usb_comma_align_ctrl_if.slave  bus
);

  localparam logic [9:0] K285_RDN = 10'h17C;
`ifdef USB_ALIGN_RDPOS_EN
  localparam logic [9:0] K285_RDP = 10'h283;
`endif
  localparam logic [3:0] LP_VC = 4'(VERIFY_COMMAS);
  localparam logic [3:0] LP_EL = 4'(ERR_LIMIT);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t     r_state;
  logic [3:0] r_bit_cnt;
  logic [3:0] r_comma_cnt;
  logic [3:0] r_err_cnt;
  logic [9:0] r_sym_out;
  logic       r_sym_valid;
  logic       r_sym_is_comma;
  logic       r_locked;
  logic       r_lock_lost;

  state_t     w_state_nxt;
  logic [3:0] w_bit_cnt_nxt;
  logic [3:0] w_comma_cnt_nxt;
  logic [3:0] w_err_cnt_nxt;
  logic       w_emit;
  logic       w_match;
  logic       w_boundary;
  logic [3:0] w_bit_wrap;
  logic [3:0] w_comma_inc;
  logic [3:0] w_err_inc;
  logic       w_lost;

`ifdef USB_ALIGN_RDPOS_EN
  assign w_match = (bus.par_in == K285_RDN) || (bus.par_in == K285_RDP);
`else
  assign w_match = (bus.par_in == K285_RDN);
`endif

  assign w_boundary  = (r_bit_cnt == 4'd9);
  assign w_bit_wrap  = w_boundary ? 4'd0 : r_bit_cnt + 4'd1;
  assign w_comma_inc = r_comma_cnt + 4'd1;
  assign w_err_inc   = r_err_cnt + 4'd1;

  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_comma_cnt_nxt = r_comma_cnt;
    w_err_cnt_nxt   = r_err_cnt;
    w_emit          = 1'b0;
    if (!bus.align_en) begin
      w_state_nxt     = ST_HUNT;
      w_bit_cnt_nxt   = 4'd0;
      w_comma_cnt_nxt = 4'd0;
      w_err_cnt_nxt   = 4'd0;
    end else begin
      case (r_state)
        ST_HUNT: begin
          w_bit_cnt_nxt = 4'd0;
          if (w_match) begin
            w_comma_cnt_nxt = 4'd1;
            // A single-comma lock emits the locking comma straight from HUNT
            if (LP_VC == 4'd1) begin
              w_state_nxt = ST_LOCKED;
              w_emit      = 1'b1;
            end else begin
              w_state_nxt = ST_VERIFY;
            end
          end
        end
        ST_VERIFY: begin
          w_bit_cnt_nxt = w_bit_wrap;
          if (w_match && w_boundary) begin
            w_comma_cnt_nxt = w_comma_inc;
            if (w_comma_inc == LP_VC) begin
              w_state_nxt = ST_LOCKED;
              w_emit      = 1'b1;
            end
          end else if (w_match) begin
            w_bit_cnt_nxt   = 4'd0;
            w_comma_cnt_nxt = 4'd1;
          end
        end
        ST_LOCKED: begin
          w_bit_cnt_nxt = w_bit_wrap;
          w_emit        = w_boundary;
          if (w_match && w_boundary) begin
            w_err_cnt_nxt = 4'd0;
          end else if (w_match) begin
            if (w_err_inc == LP_EL) begin
              w_state_nxt     = ST_HUNT;
              w_bit_cnt_nxt   = 4'd0;
              w_comma_cnt_nxt = 4'd0;
              w_err_cnt_nxt   = 4'd0;
            end else begin
              w_err_cnt_nxt = w_err_inc;
            end
          end
        end
        default: begin
          w_state_nxt     = ST_HUNT;
          w_bit_cnt_nxt   = 4'd0;
          w_comma_cnt_nxt = 4'd0;
          w_err_cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  assign w_lost = (r_state == ST_LOCKED) && (w_state_nxt == ST_HUNT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= ST_HUNT;
      r_bit_cnt      <= 4'd0;
      r_comma_cnt    <= 4'd0;
      r_err_cnt      <= 4'd0;
      r_sym_out      <= 10'd0;
      r_sym_valid    <= 1'b0;
      r_sym_is_comma <= 1'b0;
      r_locked       <= 1'b0;
      r_lock_lost    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_comma_cnt <= w_comma_cnt_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
      r_sym_valid <= w_emit;
      r_locked    <= (w_state_nxt == ST_LOCKED);
      r_lock_lost <= w_lost;
      // sym_out and sym_is_comma hold between symbols, including while disabled
      if (w_emit) begin
        r_sym_out      <= bus.par_in;
        r_sym_is_comma <= w_match;
      end
    end
  end

  assign bus.sym_out      = r_sym_out;
  assign bus.sym_valid    = r_sym_valid;
  assign bus.sym_is_comma = r_sym_is_comma;
  assign bus.locked       = r_locked;
  assign bus.lock_lost    = r_lock_lost;

endmodule

// File: tb/tb_usb_comma_align_ctrl.sv
// Bench for usb_comma_align_ctrl: directed scenarios plus random traffic against a cycle-anchored model.
module tb_usb_comma_align_ctrl;
  localparam int VC = 3;
  localparam int EL = 4;
  localparam logic [9:0] CN = 10'h17C;
  localparam logic [9:0] CP = 10'h283;

  logic clk = 1'b0;
  logic rst;
  usb_comma_align_ctrl_if bus();

  usb_comma_align_ctrl #(.VERIFY_COMMAS(VC), .ERR_LIMIT(EL)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_comma(input logic [9:0] v);
`ifdef USB_ALIGN_RDPOS_EN
    return (v == CN) || (v == CP);
`else
    return (v == CN);
`endif
  endfunction

  function automatic logic [9:0] rnd_data();
    logic [9:0] v;
    do v = 10'($urandom_range(0, 1023)); while (v == CN || v == CP);
    return v;
  endfunction

  // Model: boundaries are every 10th cycle after the anchoring comma's cycle.
  int cyc = 0, ms = 0, anchor = 0, ccnt = 0, ecnt = 0;
  logic [9:0] e_out = '0;
  logic e_val = 0, e_isc = 0, e_lock = 0, e_lost = 0;

  always @(posedge clk) begin : model
    bit m, bnd, emit, lost;
    cyc++;
    emit = 0; lost = 0;
    if (!rst) begin
      ms = 0; ccnt = 0; ecnt = 0; anchor = 0;
      e_out = '0; e_isc = 0;
    end else if (!bus.align_en) begin
      lost = (ms == 2);
      ms = 0; ccnt = 0; ecnt = 0;
    end else begin
      m   = is_comma(bus.par_in);
      bnd = (ms != 0) && (cyc > anchor) && ((cyc - anchor) % 10 == 0);
      if (ms == 0) begin
        if (m) begin
          anchor = cyc; ccnt = 1;
          if (VC == 1) begin ms = 2; emit = 1; end else ms = 1;
        end
      end else if (ms == 1) begin
        if (m && bnd) begin
          ccnt++;
          if (ccnt == VC) begin ms = 2; emit = 1; end
        end else if (m) begin
          anchor = cyc; ccnt = 1;
        end
      end else begin
        emit = bnd;
        if (m && bnd) ecnt = 0;
        else if (m) begin
          ecnt++;
          if (ecnt == EL) begin ms = 0; lost = 1; ecnt = 0; ccnt = 0; end
        end
      end
      if (emit) begin e_out = bus.par_in; e_isc = m; end
    end
    e_val  = emit;
    e_lost = lost;
    e_lock = (ms == 2);
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("locked", 32'(bus.locked), 32'(e_lock));
      chk("lock_lost", 32'(bus.lock_lost), 32'(e_lost));
      chk("sym_valid", 32'(bus.sym_valid), 32'(e_val));
      chk("sym_out", 32'(bus.sym_out), 32'(e_out));
      if (e_val) chk("sym_is_comma", 32'(bus.sym_is_comma), 32'(e_isc));
    end
  end

  task automatic step(input logic [9:0] p, input logic en);
    @(negedge clk);
    bus.par_in   = p;
    bus.align_en = en;
  endtask

  task automatic data_n(input int n);
    repeat (n) step(rnd_data(), 1'b1);
  endtask

  task automatic frame(input logic [9:0] b, input int mis);
    step(b, 1'b1);
    for (int k = 1; k <= 9; k++) step((k == mis) ? CN : rnd_data(), 1'b1);
  endtask

  task automatic acquire(input logic [9:0] c);
    step(c, 1'b1); data_n(9); step(c, 1'b1); data_n(9); step(c, 1'b1);
  endtask

  initial begin : main
    int nv;
    int ph;
    rst = 1'b0;
    bus.par_in = 10'($urandom_range(0, 1023));
    bus.align_en = 1'b1;
    @(negedge clk);
    chk_on = 1'b1;
    chk("rst_locked", 32'(bus.locked), 0);
    chk("rst_valid", 32'(bus.sym_valid), 0);
    chk("rst_sym_out", 32'(bus.sym_out), 0);
    chk("rst_lock_lost", 32'(bus.lock_lost), 0);
    bus.par_in = 10'($urandom_range(0, 1023));
    @(negedge clk);
    rst = 1'b1;
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      step(rnd_data(), 1'b1);
      if (bus.sym_valid) nv++;
    end
    chk("idle_no_valid", 32'(nv), 0);

    // Acquire: commas at t, t+10, t+20
    acquire(CN);
    chk("pre_lock", 32'(bus.locked), 0);
    step(rnd_data(), 1'b1);
    chk("lock_t21", 32'(bus.locked), 1);
    chk("valid_t21", 32'(bus.sym_valid), 1);
    chk("first_sym", 32'(bus.sym_out), 32'h17C);
    chk("first_isc", 32'(bus.sym_is_comma), 1);
    data_n(8);
    step(rnd_data(), 1'b1);
    step(rnd_data(), 1'b1);
    chk("valid_t31", 32'(bus.sym_valid), 1);
    data_n(8);

    // Loss of lock after 4 misaligned commas
    repeat (3) frame(rnd_data(), 3);
    step(rnd_data(), 1'b1); data_n(2); step(CN, 1'b1);
    step(rnd_data(), 1'b1);
    chk("lost_pulse", 32'(bus.lock_lost), 1);
    chk("lost_unlocked", 32'(bus.locked), 0);
    step(rnd_data(), 1'b1);
    chk("lost_one_cycle", 32'(bus.lock_lost), 0);
    chk("lost_no_valid", 32'(bus.sym_valid), 0);

    // Re-acquire, then an aligned comma after 3 misaligned keeps lock
    acquire(CN); data_n(9);
    chk("reacq_lock", 32'(bus.locked), 1);
    repeat (3) frame(rnd_data(), 3);
    frame(CN, 0);
    frame(rnd_data(), 3);
    chk("keep_lock", 32'(bus.locked), 1);

    // align_en drop while locked
    step(rnd_data(), 1'b0);
    step(rnd_data(), 1'b0);
    chk("en_lost_pulse", 32'(bus.lock_lost), 1);
    chk("en_unlocked", 32'(bus.locked), 0);
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      step((i == 4) ? CN : rnd_data(), 1'b0);
      if (bus.sym_valid) nv++;
    end
    chk("en_no_valid", 32'(nv), 0);

    // VERIFY re-align: commas at t, t+13, t+23, t+33
    step(CN, 1'b1); data_n(12);
    step(CN, 1'b1); data_n(9);
    step(CN, 1'b1); data_n(9);
    step(CN, 1'b1);
    chk("realign_pre", 32'(bus.locked), 0);
    step(rnd_data(), 1'b1);
    chk("realign_lock_t34", 32'(bus.locked), 1);
    chk("realign_valid_t34", 32'(bus.sym_valid), 1);

    // RD+ comma handling
    step(rnd_data(), 1'b0);
    acquire(CP);
    step(rnd_data(), 1'b1);
`ifdef USB_ALIGN_RDPOS_EN
    chk("rdpos_lock", 32'(bus.locked), 1);
`else
    chk("rdpos_lock", 32'(bus.locked), 0);
`endif

    // Reset mid-lock is silent
    step(rnd_data(), 1'b0);
    acquire(CN);
    step(rnd_data(), 1'b1);
    chk("mid_lock", 32'(bus.locked), 1);
    rst = 1'b0;
    step(rnd_data(), 1'b1);
    chk("rst_mid_no_lost", 32'(bus.lock_lost), 0);
    chk("rst_mid_unlocked", 32'(bus.locked), 0);
    rst = 1'b1;

    // Random traffic: commas biased onto one phase, plus stray commas, drops and resets
    ph = $urandom_range(0, 9);
    for (int i = 0; i < 4000; i++) begin
      int r;
      logic [9:0] p;
      logic en;
      r = $urandom_range(0, 999);
      p = rnd_data();
      en = !(r >= 3 && r < 10);
      if ((i % 10) == ph && r[0]) p = r[1] ? CN : CP;
      if (r >= 900 && r < 925) p = CN;
      step(p, en);
      rst = (r < 2) ? 1'b0 : 1'b1;
    end
    rst = 1'b1;
    repeat (3) step(rnd_data(), 1'b1);
    @(negedge clk);
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/usb_comma_align_ctrl.md
# usb_comma_align_ctrl

Symbol-alignment controller for the receive path. It sits directly after the 10-bit serial-to-parallel shift register and watches that register's output every bit clock for the K28.5 comma. It establishes and tracks the 10-bit symbol boundary and emits one aligned 10-bit symbol per boundary with a valid strobe. It declares lock only after repeated aligned commas, and drops lock after repeated misaligned commas.

## Interface
- VERIFY_COMMAS, 3: number of aligned commas (including the first) required to enter LOCKED; legal range 1..15.
- ERR_LIMIT, 4: number of misaligned commas in LOCKED that forces re-hunt; legal range 1..15.
- clk  input  1  bit clock, shared with the deserializer; all logic on posedge.
- rst  input  1  reset, synchronous, active-low.
- par_in  input  10  deserializer window, new bit shifted in at bit 9, so the oldest bit is at bit 0.
- align_en  input  1  enables alignment; low forces HUNT.
- sym_out  output  10  aligned symbol; bit 0 = first received bit (a).
- sym_valid  output  1  one-cycle strobe qualifying sym_out.
- sym_is_comma  output  1  sym_out is a comma; qualified by sym_valid.
- locked  output  1  high while state is LOCKED.
- lock_lost  output  1  one-cycle pulse on the LOCKED to HUNT transition.

## Operation
- Comma match when par_in == 10'h17C (K28.5, RD-). A second pattern is matched only if the configuration macro is defined (see Configuration).
- bit_cnt, 4 bits, runs 0..9 and wraps to 0. A boundary is the cycle in which bit_cnt == 9.
- Any comma seen while bit_cnt != 9 is a misaligned comma.
- States: HUNT, VERIFY, LOCKED.
- HUNT:
  - On comma: bit_cnt ← 0, comma_cnt ← 1, go to VERIFY. If VERIFY_COMMAS == 1, go directly to LOCKED instead.
  - Otherwise bit_cnt holds at 0.
- VERIFY:
  - Aligned comma at a boundary: comma_cnt++. When comma_cnt reaches VERIFY_COMMAS, go to LOCKED.
  - Non-comma at a boundary: no change.
  - Misaligned comma: re-align. bit_cnt ← 0, comma_cnt ← 1, stay in VERIFY.
- LOCKED:
  - Every boundary emits a symbol.
  - Aligned comma: err_cnt ← 0.
  - Misaligned comma: err_cnt++. When it reaches ERR_LIMIT, go to HUNT, pulse lock_lost, and clear bit_cnt, comma_cnt and err_cnt.
  - bit_cnt is not re-aligned in LOCKED.
- Symbol emission: at a boundary where the current state is LOCKED, or where the transition into LOCKED occurs, register sym_out ← par_in, sym_is_comma ← match, sym_valid ← 1. The locking comma itself is emitted.
- align_en low: next edge forces HUNT, clears all counters and sym_valid. lock_lost pulses if the previous state was LOCKED. sym_out holds its value.
- An aligned and a misaligned comma cannot coincide, because their definitions are exclusive.

## Timing
- Reset (rst low at a posedge) produces the following on that same edge: state=HUNT, bit_cnt=0, comma_cnt=0, err_cnt=0, sym_out=0, sym_valid=0, sym_is_comma=0, locked=0, lock_lost=0.
- A reset asserted mid-lock discards lock silently; lock_lost does not pulse.
- Latency is 1 cycle from the boundary cycle (par_in sampled) to sym_valid/sym_out.
- Steady-state lock gives a sym_valid spacing of exactly 10 cycles.
- With a first comma detected at cycle t, boundaries fall at t+10k. locked rises at cycle t+10·(VERIFY_COMMAS−1)+1, in the same cycle as the first sym_valid.
- locked is registered and falls in the same cycle lock_lost is high.

## Configuration
- USB_ALIGN_RDPOS_EN:
  - Defined: comma match also accepts 10'h283 (K28.5, RD+). Both polarities count for alignment, verify and error tracking.
  - Undefined: only 10'h17C matches; 10'h283 is treated as ordinary data.

## Test plan
- Reset: drive rst=0 for 2 cycles with random par_in. Required: all outputs 0 and locked=0; no sym_valid for 20 cycles while par_in carries no comma.
- Acquire, defaults: inject 10'h17C at t, t+10 and t+20. Required: locked=1 at t+21; sym_valid at t+21, t+31, …; first sym_out=10'h17C with sym_is_comma=1.
- VERIFY re-align: comma at t, then a comma at t+13. Required: comma_cnt restarts and boundaries move to t+23, t+33. Lock is reached at t+34 only if commas appear at t+23 and t+33.
- Loss of lock: once locked, inject 4 misaligned commas (no aligned comma between them). Required: lock_lost pulses one cycle after the 4th, then locked=0 and sym_valid=0. With an aligned comma after the 3rd misaligned one, lock is kept.
- align_en: drop align_en while LOCKED. Required: lock_lost pulse, locked=0 next cycle, no further sym_valid.
- Macro: with USB_ALIGN_RDPOS_EN defined, 10'h283 ×3 at 10-cycle spacing must achieve lock. Undefined, the same stimulus must leave locked=0.
